// File: rtl/ram_dp_bist.sv
// Dual-port RAM self-test initiator: write/read-back of an address-seeded pattern in two passes, port roles swapped in pass 1.
// Latency: start accepted at edge E0 -> done after edge E0 + 4*DEPTH + 4; no backpressure, start is ignored while busy.
module ram_dp_bist #(
   parameter int DW = 8,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] pattern,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW+1:0] err_count,
   output logic [AW-1:0] fail_addr,
   output logic          fail_pass,
   output logic [DW-1:0] d1,
   output logic [DW-1:0] d2,
   output logic          we1,
   output logic          we2,
   output logic [AW-1:0] add1,
   output logic [AW-1:0] add2,
   input  logic [DW-1:0] q1,
   input  logic [DW-1:0] q2
);

   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] LAST = (AW+1)'(DEPTH-1);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

   function automatic logic [DW-1:0] exp_f(input logic [AW-1:0] a, input logic p, input logic [DW-1:0] pat);
      logic [DW-1:0] v;
      v = pat ^ DW'(a);
      return p ? ~v : v;
   endfunction

   state_t        state_q, state_d;
   logic [AW:0]   addr_q, addr_d;
   logic          pidx_q, pidx_d;
   logic [DW-1:0] pat_q, pat_d;
   logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [AW+1:0] err_q, err_d;
   logic [AW-1:0] faddr_q, faddr_d;
   logic          fpass_q, fpass_d;
   logic          we1_q, we1_d, we2_q, we2_d;
   logic [AW-1:0] add1_q, add1_d, add2_q, add2_d;
   logic [DW-1:0] d1_q, d1_d, d2_q, d2_d;
   // Compare pipeline: stage 1 = address on the RAM pins, stage 2 = RAM data valid next edge
   logic          v1_q, v2_q, p1_q, p2_q;
   logic [AW-1:0] a1_q, a2_q;
   logic [DW-1:0] e1_q, e2_q;
   logic          accept, rd_issue, mism;
   logic [DW-1:0] rdat, wexp;

   assign accept = (state_q == S_IDLE) && start;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pidx_d  = pidx_q;
      pat_d   = pat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WR;
               addr_d  = '0;
               pidx_d  = 1'b0;
               pat_d   = pattern;
            end
         end
         S_WR: begin
            if (addr_q == LAST) begin
               state_d = S_RD;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_RD: begin
            // addr restarts at 0 to double as the drain cycle counter
            if (addr_q == LAST) begin
               state_d = S_DRAIN;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (addr_q == (AW+1)'(1)) begin
               addr_d = '0;
               if (!pidx_q) begin
                  state_d = S_WR;
                  pidx_d  = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // RAM-side outputs are computed from the next state so they register on the same edge
   always_comb begin
      we1_d    = 1'b0;
      we2_d    = 1'b0;
      add1_d   = '0;
      add2_d   = '0;
      d1_d     = '0;
      d2_d     = '0;
      rd_issue = 1'b0;
      wexp     = exp_f(addr_d[AW-1:0], pidx_d, pat_d);
      if (state_d == S_WR) begin
         if (!pidx_d) begin
            we1_d  = 1'b1;
            add1_d = addr_d[AW-1:0];
            d1_d   = wexp;
         end else begin
            we2_d  = 1'b1;
            add2_d = addr_d[AW-1:0];
            d2_d   = wexp;
         end
      end else if (state_d == S_RD) begin
         rd_issue = 1'b1;
         if (!pidx_d) add2_d = addr_d[AW-1:0];
         else         add1_d = addr_d[AW-1:0];
      end
   end

   always_comb begin
      rdat    = p2_q ? q1 : q2;
      mism    = v2_q && (rdat != e2_q);
      err_d   = err_q;
      faddr_d = faddr_q;
      fpass_d = fpass_q;
      pass_d  = pass_q;
      if (accept) begin
         err_d   = '0;
         faddr_d = '0;
         fpass_d = 1'b0;
         pass_d  = 1'b0;
      end else if (mism) begin
         err_d = err_q + 1'b1;
         if (err_q == '0) begin
            faddr_d = a2_q;
            fpass_d = p2_q;
         end
      end
      if (state_d == S_DONE) pass_d = (err_d == '0);
      busy_d = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         pidx_q  <= 1'b0;
         pat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         faddr_q <= '0;
         fpass_q <= 1'b0;
         we1_q   <= 1'b0;
         we2_q   <= 1'b0;
         add1_q  <= '0;
         add2_q  <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         p1_q    <= 1'b0;
         p2_q    <= 1'b0;
         a1_q    <= '0;
         a2_q    <= '0;
         e1_q    <= '0;
         e2_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pidx_q  <= pidx_d;
         pat_q   <= pat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         faddr_q <= faddr_d;
         fpass_q <= fpass_d;
         we1_q   <= we1_d;
         we2_q   <= we2_d;
         add1_q  <= add1_d;
         add2_q  <= add2_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         v1_q    <= rd_issue;
         p1_q    <= pidx_d;
         a1_q    <= addr_d[AW-1:0];
         e1_q    <= wexp;
         v2_q    <= v1_q;
         p2_q    <= p1_q;
         a2_q    <= a1_q;
         e2_q    <= e1_q;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_addr = faddr_q;
   assign fail_pass = fpass_q;
   assign we1       = we1_q;
   assign we2       = we2_q;
   assign add1      = add1_q;
   assign add2      = add2_q;
   assign d1        = d1_q;
   assign d2        = d2_q;

endmodule

// File: tb/tb_ram_dp_bist.sv
// Bench for ram_dp_bist: behavioural dual-port RAM with injectable faults, per-cycle timing table and a result scoreboard.
module tb_ram_dp_bist;

   typedef struct packed {
      logic       pass;
      logic [7:0] err;
      logic [5:0] faddr;
      logic       fpass;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [7:0] pattern;
   logic       busy, done, pass, fail_pass, we1, we2;
   logic [7:0] err_count, d1, d2, q1, q2;
   logic [5:0] fail_addr, add1, add2;

   int checks = 0;
   int failures = 0;

   // fault configuration: 0 ideal, 1 one stuck bit, 2 port-2 writes dropped
   int   fmode = 0;
   int   saddr = 0;
   int   sbit = 0;
   logic sval = 1'b0;

   logic [7:0] ram [64];

   int         cyc = 0;
   logic       chk_en = 1'b0;
   logic       active = 1'b0;
   int         e0 = 0;
   int         next_ok = 0;
   logic [7:0] cur_pat = '0;
   res_t       held = '0;
   res_t       sb[$];
   int         done_seen = 0;

   ram_dp_bist #(.DW(8), .AW(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_addr(fail_addr), .fail_pass(fail_pass),
      .d1(d1), .d2(d2), .we1(we1), .we2(we2), .add1(add1), .add2(add2),
      .q1(q1), .q2(q2)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ev(input int a, input logic p, input logic [7:0] pat);
      logic [7:0] v;
      v = pat ^ 8'(a);
      return p ? ~v : v;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [5:0] a);
      logic [7:0] v;
      v = ram[a];
      if (fmode == 1 && int'(a) == saddr) v[sbit] = sval;
      return v;
   endfunction

   // Whole-test outcome derived directly from the algorithm on a plain array
   function automatic res_t ref_run(input logic [7:0] pat, input int mode, input int sa, input int sbi, input logic sv);
      res_t       r;
      logic [7:0] mem [64];
      logic [7:0] rd;
      r = '0;
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < 64; a++)
            if (!(p == 1 && mode == 2)) mem[a] = ev(a, p[0], pat);
         for (int a = 0; a < 64; a++) begin
            rd = mem[a];
            if (mode == 1 && a == sa) rd[sbi] = sv;
            if (rd != ev(a, p[0], pat)) begin
               if (r.err == 0) begin
                  r.faddr = 6'(a);
                  r.fpass = p[0];
               end
               r.err = r.err + 8'd1;
            end
         end
      end
      r.pass = (r.err == 0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = '0;
   end

   always @(posedge clk) begin
      if (we1) ram[add1] <= d1;
      if (we2 && fmode != 2) ram[add2] <= d2;
      q1 <= ram_rd(add1);
      q2 <= ram_rd(add2);
   end

   // Reference of test acceptance and timing, driven only by the bench's own inputs
   always @(posedge clk) begin
      cyc++;
      if (active && cyc - e0 >= 261) active = 1'b0;
      if (!rst_n) begin
         chk_en  = 1'b1;
         active  = 1'b0;
         held    = '0;
         next_ok = cyc + 1;
         sb.delete();
      end else if (start && cyc >= next_ok) begin
         active  = 1'b1;
         e0      = cyc;
         next_ok = cyc + 262;
         cur_pat = pattern;
         held    = '0;
         sb.push_back(ref_run(pattern, fmode, saddr, sbit, sval));
      end
   end

   // Monitor: per-cycle RAM-side/busy/done table plus result scoreboard on done
   always @(negedge clk) begin
      int         o;
      logic       ewe1, ewe2, eb, ed;
      logic [5:0] ea1, ea2;
      logic [7:0] ed1, ed2;
      res_t       r;
      if (chk_en) begin
         o = active ? cyc - e0 : -1;
         ewe1 = 0; ewe2 = 0; ea1 = 0; ea2 = 0; ed1 = 0; ed2 = 0;
         eb = active && o <= 259;
         ed = active && o == 260;
         if (active) begin
            if (o < 64) begin
               ewe1 = 1; ea1 = 6'(o); ed1 = ev(o, 1'b0, cur_pat);
            end else if (o < 128) begin
               ea2 = 6'(o - 64);
            end else if (o >= 130 && o < 194) begin
               ewe2 = 1; ea2 = 6'(o - 130); ed2 = ev(o - 130, 1'b1, cur_pat);
            end else if (o >= 194 && o < 258) begin
               ea1 = 6'(o - 194);
            end
         end
         chk("ram_side", 64'({we1, we2, add1, add2, d1, d2}), 64'({ewe1, ewe2, ea1, ea2, ed1, ed2}));
         chk("busy", 64'(busy), 64'(eb));
         chk("done", 64'(done), 64'(ed));
         if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
               chk("done_without_test", 64'(1), 64'(0));
            end else begin
               r = sb.pop_front();
               chk("result", 64'({pass, err_count, fail_addr, fail_pass}), 64'(r));
               held = r;
            end
         end else if (!active) begin
            chk("result_hold", 64'({pass, err_count, fail_addr, fail_pass}), 64'(held));
         end
      end
   end

   task automatic wait_idle();
      int i;
      for (i = 0; i < 700 && (active || sb.size() != 0); i++) @(negedge clk);
      chk("test_timeout", 64'(active || sb.size() != 0), 64'(0));
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic set_cfg(input logic [7:0] pat, input int m, input int sa, input int sbi, input logic sv);
      pattern = pat; fmode = m; saddr = sa; sbit = sbi; sval = sv;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; pattern = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      set_cfg(8'hA5, 0, 0, 0, 1'b0);
      pulse_start();
      wait_idle();

      set_cfg(8'h00, 1, 5, 3, 1'b1);
      pulse_start();
      wait_idle();

      set_cfg(8'h3C, 2, 0, 0, 1'b0);
      pulse_start();
      wait_idle();

      // restart attempts while busy
      set_cfg(8'h5A, 1, 17, 6, 1'b0);
      pulse_start();
      repeat (49) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (149) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // reset mid-test, then a clean run
      set_cfg(8'hC3, 0, 0, 0, 1'b0);
      pulse_start();
      repeat (99) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      wait_idle();

      // start held high: back-to-back tests, pattern changed after the first is accepted
      begin
         int d0;
         int i;
         set_cfg(8'h00, 1, 5, 3, 1'b1);
         d0 = done_seen;
         @(negedge clk);
         start = 1'b1;
         repeat (5) @(negedge clk);
         pattern = 8'h08;
         for (i = 0; i < 1000 && done_seen < d0 + 2; i++) @(negedge clk);
         start = 1'b0;
         chk("held_start_dones", 64'(done_seen - d0), 64'(2));
         wait_idle();
      end

      for (int k = 0; k < 6; k++) begin
         set_cfg(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         pulse_start();
         wait_idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

endmodule
